// File: rtl/terminal_char_sender.sv
// Transmit side of the video terminal's parallel character port. Host bytes are
// buffered in a FIFO and sent one at a time using a rd/da/rda_n four-phase handshake.
module terminal_char_sender #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter bit UPCASE         = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_mr_n,
  input  logic [7:0]                    i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic [7:1]                    o_rd,
  output logic                          o_da,
  input  logic                          i_rda_n,
  output logic                          o_busy,
  output logic                          o_timeout,
  input  logic                          i_clr_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [6:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [1:0]    r_rda_sync;
  logic [1:0]    r_state;
  logic [CW-1:0] r_wait;
  logic [6:0]    r_rd;
  logic          r_da;
  logic          r_timeout;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_rda_s;
  logic          w_wait_done;
  logic [6:0]    w_head;
  logic [6:0]    w_char;
  logic          w_unused_bit7;

  assign w_unused_bit7 = i_tx_data[7];
  assign w_rda_s       = r_rda_sync[1];
  assign w_full        = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_empty       = (r_wptr == r_rptr);
  assign w_push        = i_tx_valid && !w_full;
  assign w_pop         = (r_state == S_IDLE) && !w_empty;
  assign w_wait_done   = (r_wait == CW'(TIMEOUT_CYCLES - 1));

  // Lowercase folding happens on the way out of the FIFO, just before rd is loaded.
  assign w_head = r_mem[r_rptr[AW-1:0]];
  assign w_char = (UPCASE && (w_head >= 7'h61) && (w_head <= 7'h7A)) ? (w_head - 7'h20) : w_head;

  assign o_tx_ready   = !w_full;
  assign o_fifo_count = r_wptr - r_rptr;
  assign o_busy       = (r_state != S_IDLE) || !w_empty;
  assign o_rd         = r_rd;
  assign o_da         = r_da;
  assign o_timeout    = r_timeout;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_tx_data[6:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_mr_n) begin
    if (!i_mr_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rda_sync <= 2'b11;
    end else begin
      r_rda_sync <= {r_rda_sync[0], i_rda_n};
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  // A set of timeout is written after the clear so that it wins in the same cycle.
  always_ff @(posedge i_clk or negedge i_mr_n) begin
    if (!i_mr_n) begin
      r_state   <= S_IDLE;
      r_rd      <= '0;
      r_da      <= 1'b0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (i_clr_timeout) begin
        r_timeout <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_rd    <= w_char;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_da    <= 1'b1;
          r_wait  <= '0;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          if (!w_rda_s) begin
            r_da    <= 1'b0;
            r_state <= S_RELEASE;
          end else if (w_wait_done) begin
            r_da      <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_RELEASE;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        S_RELEASE: begin
          if (w_rda_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_terminal_char_sender.sv
// Scoreboard bench for terminal_char_sender: two instances (UPCASE on/off) share stimulus;
// a negedge monitor compares each character presented on da against queued expectations.
module tb_terminal_char_sender;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       mrN;
  logic [7:0] txData;
  logic       txValid;
  logic       clrTimeout;
  logic       rdaN;
  logic       manualRdaN;
  logic       autoRdaN = 1'b1;
  bit         termAuto = 1'b0;

  logic       txReady0, da0, busy0, timeout0;
  logic [7:1] rd0;
  logic [2:0] count0;
  logic       txReady1, da1, busy1, timeout1;
  logic [7:1] rd1;
  logic [2:0] count1;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] expQ0[$];
  logic [6:0] expQ1[$];
  logic       prevDa0 = 1'b0;
  logic       prevDa1 = 1'b0;
  int         curLen0 = 0;
  int         lastLen0 = 0;

  always #5 clk = ~clk;

  assign rdaN = termAuto ? autoRdaN : manualRdaN;

  terminal_char_sender #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .UPCASE(1'b1)) dut0 (
    .i_clk(clk), .i_mr_n(mrN), .i_tx_data(txData), .i_tx_valid(txValid),
    .o_tx_ready(txReady0), .o_rd(rd0), .o_da(da0), .i_rda_n(rdaN),
    .o_busy(busy0), .o_timeout(timeout0), .i_clr_timeout(clrTimeout), .o_fifo_count(count0)
  );

  terminal_char_sender #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .UPCASE(1'b0)) dut1 (
    .i_clk(clk), .i_mr_n(mrN), .i_tx_data(txData), .i_tx_valid(txValid),
    .o_tx_ready(txReady1), .o_rd(rd1), .o_da(da1), .i_rda_n(rdaN),
    .o_busy(busy1), .o_timeout(timeout1), .i_clr_timeout(clrTimeout), .o_fifo_count(count1)
  );

  function automatic logic [6:0] refChar(input logic [7:0] b, input bit up);
    int c;
    c = b % 128;
    if (up && c >= 'h61 && c <= 'h7A) c = c - 'h20;
    return 7'(c);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, output bit acc);
    txData  = b;
    txValid = 1'b1;
    acc     = txReady0;
    if (acc) begin
      expQ0.push_back(refChar(b, 1'b1));
      expQ1.push_back(refChar(b, 1'b0));
    end
    tick();
    txValid = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 200) begin
      applyStimulus(b, acc);
      tries++;
    end
    if (!acc) checkOutput("send accepted", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy0 || busy1 || expQ0.size() != 0 || expQ1.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("drain completes", int'(n < 3000), 1);
  endtask

  task automatic waitDaLow();
    int n = 0;
    while (da0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (da0) checkOutput("terminal da release", 1, 0);
  endtask

  // Terminal model: acks after a random delay, or occasionally never acks to force a timeout.
  initial begin
    forever begin
      @(negedge clk);
      if (termAuto && da0 && autoRdaN) begin
        if ($urandom_range(0, 7) == 0) begin
          waitDaLow();
        end else begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          autoRdaN = 1'b0;
          waitDaLow();
          repeat ($urandom_range(0, 3)) @(negedge clk);
          autoRdaN = 1'b1;
        end
      end
    end
  end

  // Every rising da must present the oldest outstanding expected character.
  always @(negedge clk) begin
    if (da0 && !prevDa0) begin
      curLen0 = 0;
      if (expQ0.size() == 0) checkOutput("dut0 unexpected char", int'(rd0), -1);
      else checkOutput("dut0 rd", int'(rd0), int'(expQ0.pop_front()));
    end
    if (da0) curLen0++;
    if (!da0 && prevDa0) lastLen0 = curLen0;
    prevDa0 = da0;
    if (da1 && !prevDa1) begin
      if (expQ1.size() == 0) checkOutput("dut1 unexpected char", int'(rd1), -1);
      else checkOutput("dut1 rd", int'(rd1), int'(expQ1.pop_front()));
    end
    prevDa1 = da1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish by %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int n;
    mrN = 1'b0; txData = '0; txValid = 1'b0; clrTimeout = 1'b0; manualRdaN = 1'b1;
    repeat (3) tick();
    checkOutput("reset da", int'(da0), 0);
    checkOutput("reset rd", int'(rd0), 0);
    checkOutput("reset count", int'(count0), 0);
    checkOutput("reset tx_ready", int'(txReady0), 1);
    checkOutput("reset busy", int'(busy0), 0);
    checkOutput("reset timeout", int'(timeout0), 0);
    checkOutput("reset dut1 idle", int'({da1, rd1, count1, busy1, timeout1}), 0);
    checkOutput("reset dut1 tx_ready", int'(txReady1), 1);
    mrN = 1'b1;
    tick();

    // Single character with a hand-timed terminal.
    applyStimulus(8'h41, acc);
    tick();
    checkOutput("setup rd", int'(rd0), 'h41);
    checkOutput("setup da", int'(da0), 0);
    tick();
    checkOutput("strobe da", int'(da0), 1);
    repeat (5) tick();
    manualRdaN = 1'b0;
    tick();
    tick();
    checkOutput("da before ack sync", int'(da0), 1);
    tick();
    checkOutput("da falls A+2", int'(da0), 0);
    repeat (3) tick();
    manualRdaN = 1'b1;
    tick();
    tick();
    checkOutput("busy at B+1", int'(busy0), 1);
    tick();
    checkOutput("busy at B+2", int'(busy0), 0);
    checkOutput("rd held", int'(rd0), 'h41);

    // Upcase folding boundaries, random terminal.
    termAuto = 1'b1;
    sendByte(8'hE1);
    sendByte(8'h7B);
    sendByte(8'h60);
    drain();
    termAuto = 1'b0;
    clrTimeout = 1'b1;
    tick();
    clrTimeout = 1'b0;
    checkOutput("clear timeout", int'(timeout0), 0);

    // Fill the FIFO while the terminal never acks; first character times out.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(8'h61 + i), acc);
      checkOutput("fill accepted", int'(acc), 1);
    end
    checkOutput("full count", int'(count0), 4);
    checkOutput("full tx_ready", int'(txReady0), 0);
    checkOutput("full dut1 count", int'(count1), 4);
    applyStimulus(8'h66, acc);
    checkOutput("write while full dropped", int'(acc), 0);
    checkOutput("count after drop", int'(count0), 4);
    n = 0;
    while (da0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("timeout da length", lastLen0, TMO);
    checkOutput("timeout flag", int'(timeout0), 1);
    tick();
    tick();
    checkOutput("count after pop", int'(count0), 3);
    checkOutput("tx_ready after pop", int'(txReady0), 1);
    termAuto = 1'b1;
    drain();
    termAuto = 1'b0;
    checkOutput("timeout sticky", int'(timeout0), 1);
    clrTimeout = 1'b1;
    tick();
    clrTimeout = 1'b0;
    checkOutput("timeout cleared", int'(timeout0), 0);

    // Stuck acknowledge, then a write coinciding with a pop.
    manualRdaN = 1'b0;
    tick();
    tick();
    applyStimulus(8'h31, acc);
    tick();
    checkOutput("stuck setup rd", int'(rd0), 'h31);
    tick();
    checkOutput("stuck da high", int'(da0), 1);
    tick();
    checkOutput("stuck da one cycle", int'(da0), 0);
    checkOutput("stuck pulse length", lastLen0, 1);
    applyStimulus(8'h32, acc);
    applyStimulus(8'h33, acc);
    checkOutput("two queued", int'(count0), 2);
    manualRdaN = 1'b1;
    repeat (3) tick();
    checkOutput("count before pop", int'(count0), 2);
    applyStimulus(8'h34, acc);
    checkOutput("simultaneous write accepted", int'(acc), 1);
    checkOutput("count after write+pop", int'(count0), 2);
    termAuto = 1'b1;
    drain();
    termAuto = 1'b0;

    // Master reset in the middle of a strobe with three bytes queued.
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h50 + i), acc);
    checkOutput("strobe before reset", int'(da0), 1);
    mrN = 1'b0;
    #1;
    checkOutput("mr da", int'(da0), 0);
    checkOutput("mr rd", int'(rd0), 0);
    checkOutput("mr count", int'(count0), 0);
    checkOutput("mr tx_ready", int'(txReady0), 1);
    checkOutput("mr busy", int'(busy0), 0);
    expQ0.delete();
    expQ1.delete();
    tick();
    tick();
    mrN = 1'b1;
    repeat (20) tick();
    checkOutput("quiet after reset", int'({busy0, da0, count0}), 0);
    termAuto = 1'b1;
    sendByte(8'h7A);
    drain();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      sendByte(8'($urandom_range(0, 255)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
